// File: rtl/oled_spi_receiver.sv
// oled_spi_receiver: SPI slave for an SSD1306-style 128x64 OLED; decodes panel commands and streams data into a framebuffer.
// Optional build macro OLED_RX_CHECKSUM_EN adds a per-frame modulo-256 data checksum on frame_sum.
`default_nettype none

module oled_spi_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int FB_BYTES    = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       io_sclk,
  input  logic       io_sdin,
  input  logic       io_cs,
  input  logic       io_dc,
  input  logic       io_reset,
  output logic       fb_we,
  output logic [9:0] fb_addr,
  output logic [7:0] fb_wdata,
  output logic       frame_done,
  output logic       display_on,
  output logic       invert,
  output logic [7:0] contrast,
  output logic [7:0] cmd_count,
  output logic [7:0] frame_sum
);

  localparam logic [9:0] LAST_ADDR = 10'(FB_BYTES - 1);

  typedef enum logic [1:0] {
    DEC_CMD          = 2'd0,
    DEC_ARG_CONTRAST = 2'd1,
    DEC_ARG_MODE     = 2'd2,
    DEC_ARG_SKIP     = 2'd3
  } dec_state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, sdin_sync, cs_sync, dc_sync, rstn_sync;
  logic                   sclk_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '1;
      sdin_sync <= '0;
      cs_sync   <= '1;
      dc_sync   <= '0;
      rstn_sync <= '1;
      sclk_prev <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], io_sclk};
      sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], io_sdin};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   io_cs};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0],   io_dc};
      rstn_sync <= {rstn_sync[SYNC_STAGES-2:0], io_reset};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
    end
  end

  logic sclk_s, sdin_s, cs_s, dc_s, soft_rst, sclk_rise;
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign sdin_s    = sdin_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign dc_s      = dc_sync[SYNC_STAGES-1];
  assign soft_rst  = ~rstn_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;

  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_dc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= 3'd0;
      shift      <= 7'd0;
      byte_valid <= 1'b0;
      byte_data  <= 8'd0;
      byte_dc    <= 1'b0;
    end else if (soft_rst) begin
      bit_cnt    <= 3'd0;
      shift      <= 7'd0;
      byte_valid <= 1'b0;
      byte_data  <= 8'd0;
      byte_dc    <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (cs_s) begin
        bit_cnt <= 3'd0;
      end else if (sclk_rise) begin
        shift   <= {shift[5:0], sdin_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid <= 1'b1;
          byte_data  <= {shift, sdin_s};
          byte_dc    <= dc_s;
        end
      end
    end
  end

  dec_state_t state;
  logic [9:0] wptr;
  // Mode argument is held but only horizontal addressing is implemented.
  logic [1:0] unused_addr_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= DEC_CMD;
      wptr             <= 10'd0;
      unused_addr_mode <= 2'd0;
      fb_we            <= 1'b0;
      fb_addr          <= 10'd0;
      fb_wdata         <= 8'd0;
      frame_done       <= 1'b0;
      display_on       <= 1'b0;
      invert           <= 1'b0;
      contrast         <= 8'h7F;
      cmd_count        <= 8'd0;
    end else if (soft_rst) begin
      state            <= DEC_CMD;
      wptr             <= 10'd0;
      unused_addr_mode <= 2'd0;
      fb_we            <= 1'b0;
      fb_addr          <= 10'd0;
      fb_wdata         <= 8'd0;
      frame_done       <= 1'b0;
      display_on       <= 1'b0;
      invert           <= 1'b0;
      contrast         <= 8'h7F;
      cmd_count        <= 8'd0;
    end else begin
      fb_we      <= 1'b0;
      frame_done <= 1'b0;
      if (byte_valid) begin
        if (byte_dc) begin
          // Data always wins: a pending argument is abandoned.
          state      <= DEC_CMD;
          fb_we      <= 1'b1;
          fb_addr    <= wptr;
          fb_wdata   <= byte_data;
          frame_done <= (wptr == LAST_ADDR);
          wptr       <= (wptr == LAST_ADDR) ? 10'd0 : wptr + 10'd1;
        end else begin
          cmd_count <= cmd_count + 8'd1;
          case (state)
            DEC_CMD: begin
              case (byte_data)
                8'hAE: display_on <= 1'b0;
                8'hAF: display_on <= 1'b1;
                8'hA6: invert     <= 1'b0;
                8'hA7: invert     <= 1'b1;
                8'h81: state      <= DEC_ARG_CONTRAST;
                8'h20: begin
                  state <= DEC_ARG_MODE;
                  wptr  <= 10'd0;
                end
                8'h21, 8'h22: wptr <= 10'd0;
                8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDB, 8'h8D: state <= DEC_ARG_SKIP;
                default: ;
              endcase
            end
            DEC_ARG_CONTRAST: begin
              contrast <= byte_data;
              state    <= DEC_CMD;
            end
            DEC_ARG_MODE: begin
              unused_addr_mode <= byte_data[1:0];
              state            <= DEC_CMD;
            end
            default: state <= DEC_CMD;
          endcase
        end
      end
    end
  end

`ifdef OLED_RX_CHECKSUM_EN
  logic [7:0] sum_acc;
  logic [7:0] sum_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_acc <= 8'd0;
      sum_reg <= 8'd0;
    end else if (soft_rst) begin
      sum_acc <= 8'd0;
      sum_reg <= 8'd0;
    end else if (byte_valid && byte_dc) begin
      if (wptr == LAST_ADDR) begin
        sum_reg <= sum_acc + byte_data;
        sum_acc <= 8'd0;
      end else begin
        sum_acc <= sum_acc + byte_data;
      end
    end
  end

  assign frame_sum = sum_reg;
`else
  assign frame_sum = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_oled_spi_receiver.sv
// Directed bench for oled_spi_receiver with a write scoreboard.
`timescale 1ns/1ps
`default_nettype none

module tb_oled_spi_receiver;

  logic       clk = 1'b0;
  logic       rst_n, io_sclk, io_sdin, io_cs, io_dc, io_reset;
  logic       fb_we, frame_done, display_on, invert;
  logic [9:0] fb_addr;
  logic [7:0] fb_wdata, contrast, cmd_count, frame_sum;

  oled_spi_receiver #(.SYNC_STAGES(2), .FB_BYTES(1024)) dut (
    .clk(clk), .rst_n(rst_n), .io_sclk(io_sclk), .io_sdin(io_sdin),
    .io_cs(io_cs), .io_dc(io_dc), .io_reset(io_reset),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .frame_done(frame_done), .display_on(display_on), .invert(invert),
    .contrast(contrast), .cmd_count(cmd_count), .frame_sum(frame_sum)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] addr;
    logic [7:0] data;
    logic       last;
  } wr_t;

  wr_t        exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         frame_cnt = 0;
  logic [9:0] exp_ptr = 10'd0;
  logic [7:0] exp_sum = 8'd0;
  logic [7:0] exp_fsum = 8'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (fb_we) begin
      e = 'x;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check("wr_addr", {22'd0, fb_addr}, {22'd0, e.addr});
      check("wr_data", {24'd0, fb_wdata}, {24'd0, e.data});
      check("wr_frame_done", {31'd0, frame_done}, {31'd0, e.last});
    end else if (frame_done) begin
      check("frame_done_without_write", {31'd0, frame_done}, 32'd0);
    end
    if (frame_done) frame_cnt++;
  end

  task automatic spi_byte(input logic [7:0] b, input logic dc, input int ph);
    @(negedge clk);
    io_cs = 1'b0;
    io_dc = dc;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      io_sclk = 1'b0;
      io_sdin = b[i];
      repeat (ph - 1) @(negedge clk);
      @(negedge clk);
      io_sclk = 1'b1;
      repeat (ph - 1) @(negedge clk);
    end
  endtask

  task automatic partial(input int n);
    @(negedge clk);
    io_cs = 1'b0;
    io_dc = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      io_sclk = 1'b0;
      io_sdin = 1'b1;
      repeat (2) @(negedge clk);
      io_sclk = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic cs_high();
    @(negedge clk);
    io_cs = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    spi_byte(b, 1'b0, 2);
  endtask

  task automatic send_data(input logic [7:0] b, input int ph);
    exp_q.push_back('{addr: exp_ptr, data: b, last: (exp_ptr == 10'd1023)});
    if (exp_ptr == 10'd1023) begin
      exp_fsum = exp_sum + b;
      exp_sum  = 8'd0;
    end else begin
      exp_sum = exp_sum + b;
    end
    exp_ptr = exp_ptr + 10'd1;
    spi_byte(b, 1'b1, ph);
  endtask

  task automatic drain(input string tag);
    repeat (10) @(negedge clk);
    check(tag, exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_fb_we"}, {31'd0, fb_we}, 32'd0);
    check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    check({tag, "_display_on"}, {31'd0, display_on}, 32'd0);
    check({tag, "_invert"}, {31'd0, invert}, 32'd0);
    check({tag, "_cmd_count"}, {24'd0, cmd_count}, 32'd0);
    check({tag, "_fb_addr"}, {22'd0, fb_addr}, 32'd0);
    check({tag, "_fb_wdata"}, {24'd0, fb_wdata}, 32'd0);
    check({tag, "_frame_sum"}, {24'd0, frame_sum}, 32'd0);
    check({tag, "_contrast"}, {24'd0, contrast}, 32'h7F);
  endtask

  logic [7:0] init_seq [23] = '{8'hAE, 8'h81, 8'h7F, 8'hA6, 8'h20, 8'h00, 8'hC8, 8'h40,
                                8'hA1, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'hD5, 8'h80, 8'hD9,
                                8'h22, 8'hDB, 8'h20, 8'h8D, 8'h14, 8'hA4, 8'hAF};

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; io_sclk = 1'b1; io_sdin = 1'b0; io_cs = 1'b1; io_dc = 1'b0; io_reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    foreach (init_seq[i]) send_cmd(init_seq[i]);
    cs_high();
    drain("init_no_write");
    check("init_cmd_count", {24'd0, cmd_count}, 32'd23);
    check("init_display_on", {31'd0, display_on}, 32'd1);
    check("init_contrast", {24'd0, contrast}, 32'h7F);
    check("init_invert", {31'd0, invert}, 32'd0);

    send_cmd(8'h81); send_cmd(8'h3C);
    cs_high();
    repeat (8) @(negedge clk);
    check("contrast_3c", {24'd0, contrast}, 32'h3C);
    send_cmd(8'hA7);
    cs_high();
    repeat (8) @(negedge clk);
    check("invert_on", {31'd0, invert}, 32'd1);
    check("cmd_count_26", {24'd0, cmd_count}, 32'd26);

    partial(5);
    cs_high();
    send_data(8'hA5, 2);
    cs_high();
    drain("partial_then_a5");
    check("a5_wdata_held", {24'd0, fb_wdata}, 32'hA5);

    send_cmd(8'h81);
    send_data(8'h55, 2);
    send_cmd(8'h10);
    cs_high();
    drain("arg_abandon");
    check("abandon_contrast", {24'd0, contrast}, 32'h3C);
    check("abandon_cmd_count", {24'd0, cmd_count}, 32'd28);

    for (int i = 0; i < 300; i++) send_data(8'(i), 1);
    cs_high();
    drain("data_300");
    @(negedge clk);
    io_reset = 1'b0;
    repeat (4) @(negedge clk);
    io_reset = 1'b1;
    repeat (8) @(negedge clk);
    exp_ptr = 10'd0;
    exp_sum = 8'd0;
    check_reset_values("io_reset");

    frame_cnt = 0;
    for (int i = 0; i < 1024; i++) send_data(8'(i), 1);
    cs_high();
    drain("frame");
    check("frame_done_count", frame_cnt, 32'd1);
`ifdef OLED_RX_CHECKSUM_EN
    check("frame_sum", {24'd0, frame_sum}, {24'd0, exp_fsum});
`else
    check("frame_sum", {24'd0, frame_sum}, 32'd0);
`endif
    send_data(8'h11, 2);
    cs_high();
    drain("after_frame_wrap");

    send_cmd(8'hAF); send_cmd(8'h81); send_cmd(8'h40); send_cmd(8'hA7);
    cs_high();
    repeat (8) @(negedge clk);
    check("pre_rst_display_on", {31'd0, display_on}, 32'd1);
    check("pre_rst_contrast", {24'd0, contrast}, 32'h40);
    check("pre_rst_cmd_count", {24'd0, cmd_count}, 32'd4);
    partial(4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("rst_mid_byte");
    @(negedge clk);
    io_cs = 1'b1; io_sclk = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_ptr = 10'd0;
    exp_sum = 8'd0;
    repeat (4) @(negedge clk);
    send_cmd(8'hAF);
    send_data(8'h3C, 2);
    cs_high();
    drain("post_rst");
    check("post_rst_display_on", {31'd0, display_on}, 32'd1);
    check("post_rst_cmd_count", {24'd0, cmd_count}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/oled_spi_receiver.md
OLED_SPI_RECEIVER -- requirements
Module: oled_spi_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the synchroniser depth applied equally to io_sclk, io_sdin, io_cs and io_dc (legal range 2..3).
REQ-002 SHALL have parameter FB_BYTES, default 1024, meaning the framebuffer size in bytes (128x64/8).
REQ-003 SHALL have port clk  input  1  system clock; one clock only.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port io_sclk  input  1  SPI clock; idles high; data is sampled on its rising edge.
REQ-006 SHALL have port io_sdin  input  1  SPI data, MSB first.
REQ-007 SHALL have port io_cs  input  1  chip select, active-low.
REQ-008 SHALL have port io_dc  input  1  data/command select (0 = command, 1 = data).
REQ-009 SHALL have port io_reset  input  1  display reset, active-low.
REQ-010 SHALL have port fb_we  output  1  framebuffer write strobe, one cycle wide.
REQ-011 SHALL have port fb_addr  output  10  framebuffer byte address.
REQ-012 SHALL have port fb_wdata  output  8  framebuffer write data.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse on the write to address FB_BYTES-1.
REQ-014 SHALL have ports display_on (1), invert (1) and contrast (8), all outputs holding decoded panel state.
REQ-015 SHALL have port cmd_count  output  8  count of accepted command bytes; wraps at 255 to 0.
REQ-016 SHALL have port frame_sum  output  8  per-frame data checksum (see Configuration).

Function
REQ-017 SHALL pass io_sclk, io_sdin, io_cs and io_dc through identical SYNC_STAGES flop chains, so the sampled data stays aligned with the sampled clock.
REQ-018 SHALL detect a rising edge of sclk as synchronised-current = 1 and previous = 0, and SHALL operate correctly with sclk high and low phases as short as 1 clk each.
REQ-019 SHALL shift sdin into an 8-bit register on each sclk rising edge while cs is low, MSB first, using a 3-bit bit counter.
REQ-020 SHALL clear the bit counter and discard a partial byte when cs is high; bytes are never completed across a cs deassertion.
REQ-021 SHALL complete a byte on the 8th rising edge and latch dc on that same edge; it SHALL be processed the following cycle (total latency SYNC_STAGES+2 clk from the io_sclk rise).
REQ-022 SHALL run a decoder FSM with states DEC_CMD, DEC_ARG_CONTRAST, DEC_ARG_MODE and DEC_ARG_SKIP.
REQ-023 SHALL, in DEC_CMD, decode command bytes as follows:
- AE: display_on = 0.
- AF: display_on = 1.
- A6: invert = 0.
- A7: invert = 1.
- 81: go to DEC_ARG_CONTRAST.
- 20: go to DEC_ARG_MODE.
- A8, D3, D5, D9, DB, 8D: go to DEC_ARG_SKIP.
- Any other byte: accept and ignore.
REQ-024 SHALL, in each DEC_ARG state, consume the next command byte as the argument and return to DEC_CMD: contrast is loaded with it; the mode argument is latched internally (only 00, horizontal addressing, is supported); DEC_ARG_SKIP discards it.
REQ-025 SHALL increment cmd_count for every completed byte with dc = 0, including arguments.
REQ-026 SHALL, for each completed byte with dc = 1, assert fb_we for one cycle with fb_wdata = byte and fb_addr = write pointer, then increment the pointer.
REQ-027 SHALL wrap the write pointer from FB_BYTES-1 to 0 and assert frame_done in the cycle of the FB_BYTES-1 write.
REQ-028 SHALL, when a data byte arrives while in a DEC_ARG state, abandon the argument, return to DEC_CMD and write the byte normally.
REQ-029 SHALL reset the write pointer to 0 on any command byte with value 20, 21 or 22 arriving in DEC_CMD.

Reset
REQ-030 SHALL, while rst_n is low, asynchronously set:
- sync chains to cs = 1, sclk = 1, sdin = 0, dc = 0;
- bit counter and write pointer to 0;
- FSM to DEC_CMD;
- fb_we, frame_done, display_on, invert and cmd_count to 0;
- fb_addr, fb_wdata and frame_sum to 0;
- contrast to 7F.
REQ-031 SHALL, while synchronised io_reset is low, synchronously apply the same values as REQ-030 except the sync chains themselves; this includes reset mid-byte and mid-frame.

Configuration
REQ-032 SHALL, with OLED_RX_CHECKSUM_EN defined, keep an 8-bit modulo-256 sum of data bytes, load it (including the final byte) into frame_sum at frame_done, then clear the accumulator; without the macro, frame_sum SHALL be constant 0 and no accumulator is built.

Verification
REQ-033 SHALL cover: 23-byte init sequence AE 81 7F A6 20 00 C8 40 A1 A8 3F D3 00 D5 80 D9 22 DB 20 8D 14 A4 AF with dc = 0 -> cmd_count = 23, display_on = 1, contrast = 7F, invert = 0, no fb_we.
REQ-034 SHALL cover: 81 then 3C with dc = 0 -> contrast = 3C; then A7 -> invert = 1.
REQ-035 SHALL cover: 1024 data bytes with value i mod 256 -> 1024 fb_we pulses at addresses 0..1023, a single frame_done on address 1023, and the next write at address 0; with OLED_RX_CHECKSUM_EN, frame_sum = 00.
REQ-036 SHALL cover: 5 sclk edges, cs high, then a full byte A5 with dc = 1 -> exactly one write, fb_wdata = A5.
REQ-037 SHALL cover: io_reset low for 4 clk after 300 data bytes -> pointer = 0, contrast = 7F, display_on = 0; the next data byte is written at address 0.
REQ-038 SHALL cover: rst_n asserted mid-byte -> all outputs at REQ-030 values in the same cycle; the next complete byte decodes correctly.
